sp_data_ram: RTL and testbench
==============================

// Module: sp_data_ram
// PURPOSE
//  Parametrised single-port data RAM replacing the fixed 4096x32 data-memory macro in the 1C102 SoC.
//  - Adds a valid/ready request channel, per-byte write strobes and a selectable 1- or 2-cycle read latency.
//  - Runs a post-reset zero-fill sequence so software sees defined contents.
//  - Sits between the core's data bus bridge and on-chip BSRAM.
// PARAMETERS
//  DATA_W          32  word width; must be a multiple of BYTE_W
//  ADDR_W          12  word address width; depth = 2**ADDR_W
//  BYTE_W           8  strobe granularity; NB = DATA_W/BYTE_W lanes
//  OUT_REG          0  0: read latency 1; 1: extra output register, latency 2
//  CLEAR_ON_RESET   1  1: zero-fill every word after reset; 0: skip to RUN
// PORTS
//  clk         in   1       clock; all logic on rising edge
//  resetn      in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when valid&&ready
//  req_wr      in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  word address
//  req_wstrb   in   NB      byte-lane write enables (ignored on reads)
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       one-cycle pulse per accepted request
//  rsp_rdata   out  DATA_W  read data; 0 for write acks
//  init_busy   out  1       high while zero-fill runs
//  parity_err  out  NB      per-lane parity mismatch (present only with SP_DATA_RAM_PARITY_EN)
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_busy=CLEAR_ON_RESET, parity_err=0.
//  - Reset clears pipeline and FSM only; array contents are never reset.
//  - FSM states:
//    - INIT: writes 0 to address cnt; cnt increments 0..2**ADDR_W-1, one word per cycle; req_ready=0.
//      At the last address it goes to RUN next cycle, so INIT lasts exactly 2**ADDR_W cycles.
//    - RUN: req_ready=1 every cycle; no response backpressure.
//  - CLEAR_ON_RESET=0: first state after reset is RUN; init_busy=0.
//  - resetn asserted mid-INIT or mid-access: everything is abandoned. No rsp_valid for an in-flight request.
//    INIT restarts from address 0 after release.
//  - Accept = req_valid && req_ready; one access per cycle; back-to-back accepts allowed.
//  - Write: only lanes with wstrb[i]=1 update.
//    - wstrb=0 still acks.
//    - Ack: rsp_valid with rsp_rdata=0, same latency as a read.
//  - Read: rsp_rdata = stored word, cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1) after accept in cycle N.
//  - Responses are in order; rsp_rdata holds its value when rsp_valid=0.
//  - Read following a write to the same address: the read returns the new data (no hazard window).
//  - Address is always in range (depth is a power of two); cnt wraps to 0 internally when INIT ends.
// CONFIGURATION
//  - SP_DATA_RAM_PARITY_EN defined:
//    - Each lane stores an even-parity bit; INIT writes parity 0.
//    - On read responses, parity_err[i]=1 when lane i mismatches. It is valid with rsp_valid and 0 otherwise.
//  - Undefined: no parity storage, and no parity_err port.
// STRUCTURE
//  - Package sp_data_ram_pkg holds:
//    - state encodings ST_INIT, ST_RUN;
//    - function nb(DATA_W,BYTE_W);
//    - parity helper function.
//  - Sub-module sp_data_ram_lane: one BYTE_W(+1 parity)-wide synchronous single-port array.
//    - NB instances, generate loop; each has we = accept && req_wr && wstrb[i] (or INIT).
//  - Top holds FSM, clear counter, latency pipeline (valid + write/read tag), output mux.
// TESTING
//  - Reset release, ADDR_W=4, CLEAR_ON_RESET=1:
//    - init_busy high exactly 16 cycles, req_ready=0 throughout;
//    - then reads of addr 0..15 all return 0.
//  - Write 0xDEADBEEF @0x10 wstrb=4'b1111, then write 0x000000AA wstrb=4'b0001 @0x10, then read @0x10:
//    - response 0xDEADBEAA, write acks carry rdata=0.
//  - OUT_REG=1, reads @1,@2,@3 accepted on consecutive cycles:
//    - rsp_valid on cycles +2,+3,+4 with matching data, in order.
//  - resetn pulsed low halfway through INIT:
//    - outputs return to reset values immediately;
//    - init restarts at 0 and completes in the full 2**ADDR_W cycles.
//  - resetn low one cycle after a read accept: no rsp_valid is ever produced for that read.
//  - With SP_DATA_RAM_PARITY_EN, write 0x12345678, force-flip bit 9 in lane 1 storage, read:
//    - parity_err=4'b0010 with rsp_valid.

Source files
------------

// File: rtl/sp_data_ram_pkg.sv
// sp_data_ram_pkg: shared definitions for sp_data_ram.
//   state_t  : controller states (ST_INIT zero-fill, ST_RUN normal service)
//   nb()     : number of byte lanes for a given word/lane width
//   even_par : even parity of up to 64 bits (callers zero-extend narrower lanes)
package sp_data_ram_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic int nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sp_data_ram_lane.sv
// sp_data_ram_lane: one byte lane of the data RAM, a synchronous single-port array.
//   clk   : clock
//   we    : write enable for this lane
//   addr  : word address
//   wdata : lane write data (byte plus optional parity bit)
//   rdata : registered read data of addr, one cycle after it is presented
// Contents are deliberately not reset.
module sp_data_ram_lane #(
    parameter int W      = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sp_data_ram.sv
// sp_data_ram: parametrised single-port data RAM with valid/ready requests,
// byte write strobes, 1- or 2-cycle read latency and post-reset zero-fill.
//   clk, resetn            : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake, accept when both high
//   req_wr/addr/wstrb/wdata: request payload (wstrb ignored on reads)
//   rsp_valid/rsp_rdata    : one response per accepted request, 0 data for write acks
//   init_busy              : high while the zero-fill runs
//   parity_err             : per-lane parity mismatch on read responses
// Optional feature: define SP_DATA_RAM_PARITY_EN to add lane parity storage and parity_err.
module sp_data_ram
    import sp_data_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int BYTE_W         = 8,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_wr,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [nb(DATA_W, BYTE_W)-1:0]   req_wstrb,
    input  logic [DATA_W-1:0]               req_wdata,
    output logic                            rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            init_busy
`ifdef SP_DATA_RAM_PARITY_EN
    ,
    output logic [nb(DATA_W, BYTE_W)-1:0]   parity_err
`endif
);

    localparam int NB = nb(DATA_W, BYTE_W);
`ifdef SP_DATA_RAM_PARITY_EN
    localparam int LW = BYTE_W + 1;
`else
    localparam int LW = BYTE_W;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              init, accept, ready_q, v1, wr1, v2;
    logic [DATA_W-1:0] word, s1, out_q;

    assign init      = state == ST_INIT;
    assign accept    = req_valid && req_ready;
    assign req_ready = ready_q;
    assign init_busy = init;

    // Zero-fill walks every address once; cnt wraps back to 0 as INIT ends.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (init) begin
            cnt_n = cnt + 1'b1;
            if (&cnt) state_n = ST_RUN;
        end
    end

    // ready is registered from the next state so it is low during reset
    // even when the controller starts directly in RUN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= CLEAR_ON_RESET != 0 ? ST_INIT : ST_RUN;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= state_n == ST_RUN;
        end
    end

    // v1/wr1 align with the lane read register; v2/out_q form the optional second stage.
    // out_q also holds the last response so rsp_rdata is stable between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1    <= 1'b0;
            wr1   <= 1'b0;
            v2    <= 1'b0;
            out_q <= '0;
        end else begin
            v1  <= accept;
            wr1 <= req_wr;
            v2  <= v1;
            if (v1) out_q <= s1;
        end
    end

`ifdef SP_DATA_RAM_PARITY_EN
    logic [NB-1:0] perr1, perr_q;
`endif

    genvar i;
    generate
        for (i = 0; i < NB; i++) begin : g_lane
            logic [BYTE_W-1:0] wb;
            logic [LW-1:0]     wd, rd;
            assign wb = req_wdata[i*BYTE_W +: BYTE_W];
`ifdef SP_DATA_RAM_PARITY_EN
            assign wd       = init ? '0 : {even_par(64'(wb)), wb};
            assign perr1[i] = v1 && !wr1 && (even_par(64'(rd[BYTE_W-1:0])) != rd[BYTE_W]);
`else
            assign wd = init ? '0 : wb;
`endif
            assign word[i*BYTE_W +: BYTE_W] = rd[BYTE_W-1:0];
            sp_data_ram_lane #(.W(LW), .ADDR_W(ADDR_W)) u_lane (
                .clk   (clk),
                .we    (init || (accept && req_wr && req_wstrb[i])),
                .addr  (init ? cnt : req_addr),
                .wdata (wd),
                .rdata (rd)
            );
        end
    endgenerate

    assign s1        = wr1 ? '0 : word;
    assign rsp_valid = OUT_REG != 0 ? v2 : v1;
    assign rsp_rdata = (OUT_REG == 0 && v1) ? s1 : out_q;

`ifdef SP_DATA_RAM_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) perr_q <= '0;
        else         perr_q <= perr1;
    end
    assign parity_err = OUT_REG != 0 ? perr_q : perr1;
`endif

endmodule

// File: tb/tb_sp_data_ram.sv
// tb_sp_data_ram: directed bench for sp_data_ram. dut0 is 16 words with 1-cycle
// latency, dut1 is 32 words with the output register; both share stimulus, so
// address 0x10 aliases to 0 in dut0 and the expected values account for that.
module tb_sp_data_ram;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic        rdy0, rv0, busy0, rdy1, rv1, busy1;
    logic [31:0] rd0, rd1;
`ifdef SP_DATA_RAM_PARITY_EN
    logic [3:0]  pe0, pe1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sp_data_ram #(.ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .resetn(resetn), .req_valid(valid), .req_ready(rdy0), .req_wr(wr),
        .req_addr(addr[3:0]), .req_wstrb(wstrb), .req_wdata(wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .init_busy(busy0)
`ifdef SP_DATA_RAM_PARITY_EN
        , .parity_err(pe0)
`endif
    );

    sp_data_ram #(.ADDR_W(5), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .resetn(resetn), .req_valid(valid), .req_ready(rdy1), .req_wr(wr),
        .req_addr(addr), .req_wstrb(wstrb), .req_wdata(wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .init_busy(busy1)
`ifdef SP_DATA_RAM_PARITY_EN
        , .parity_err(pe1)
`endif
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic w, input logic [4:0] a, input logic [3:0] s,
                                input logic [31:0] d, input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.wr = w; v.addr = a; v.strb = s; v.data = d; v.e0 = e0; v.e1 = e1;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        valid = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    endtask

    task automatic idle();
        valid = 1'b0; wr = 1'b0; wstrb = '0; wdata = '0;
    endtask

    // Releases reset at a falling edge and counts cycles with init_busy high,
    // starting with the cycle of release.
    task automatic wait_init();
        int   c0 = 0;
        int   c1 = 0;
        logic bad = 1'b0;
        resetn = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (busy0) begin
                c0++;
                if (rdy0 || rdy1) bad = 1'b1;
            end
            if (busy1) c1++;
            if (!busy0 && !busy1) break;
            @(negedge clk);
        end
        chk("init_len0", c0, 16);
        chk("init_len1", c1, 32);
        chk("ready_in_init", 32'(bad), 0);
        chk("ready_after0", 32'(rdy0), 1);
        chk("ready_after1", 32'(rdy1), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        for (int a = 0; a < 16; a++) add(0, 5'(a), 4'h0, 32'h0, 32'h0, 32'h0);
        add(1, 5'h10, 4'hF, 32'hDEADBEEF, 32'h0, 32'h0);
        add(1, 5'h10, 4'h1, 32'h000000AA, 32'h0, 32'h0);
        add(0, 5'h10, 4'h0, 32'h0, 32'hDEADBEAA, 32'hDEADBEAA);
        add(0, 5'h00, 4'h0, 32'h0, 32'hDEADBEAA, 32'h0);
        add(1, 5'h03, 4'hF, 32'h11223344, 32'h0, 32'h0);
        add(1, 5'h03, 4'h0, 32'hFFFFFFFF, 32'h0, 32'h0);
        add(0, 5'h03, 4'h0, 32'h0, 32'h11223344, 32'h11223344);
        add(1, 5'h05, 4'hA, 32'hAABBCCDD, 32'h0, 32'h0);
        add(0, 5'h05, 4'h0, 32'h0, 32'hAA00CC00, 32'hAA00CC00);
        add(1, 5'h1F, 4'h4, 32'h00770000, 32'h0, 32'h0);
        add(0, 5'h0F, 4'h0, 32'h0, 32'h00770000, 32'h0);
        add(0, 5'h1F, 4'h0, 32'h0, 32'h00770000, 32'h00770000);
        add(1, 5'h01, 4'hF, 32'h01010101, 32'h0, 32'h0);
        add(1, 5'h02, 4'hF, 32'h02020202, 32'h0, 32'h0);
        add(0, 5'h01, 4'h0, 32'h0, 32'h01010101, 32'h01010101);

        repeat (3) @(negedge clk);
        chk("rst_ready0", 32'(rdy0), 0);
        chk("rst_rsp_valid0", 32'(rv0), 0);
        chk("rst_rdata0", rd0, 0);
        chk("rst_busy0", 32'(busy0), 1);
        chk("rst_ready1", 32'(rdy1), 0);
        chk("rst_rdata1", rd1, 0);
        wait_init();

        // Back-to-back table stream: dut0 answers one cycle later, dut1 two.
        n = tv.size();
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= n) begin
                chk($sformatf("v%0d_valid0", k - 1), 32'(rv0), 1);
                chk($sformatf("v%0d_rdata0", k - 1), rd0, tv[k-1].e0);
            end else if (k == n + 1) begin
                chk("tail_valid0", 32'(rv0), 0);
            end
            if (k >= 2) begin
                chk($sformatf("v%0d_valid1", k - 2), 32'(rv1), 1);
                chk($sformatf("v%0d_rdata1", k - 2), rd1, tv[k-2].e1);
            end
            if (k < n) drive(tv[k].wr, tv[k].addr, tv[k].strb, tv[k].data);
            else idle();
        end

        // Consecutive reads @1,@2,@3 through the 2-cycle pipeline.
        drive(0, 5'h01, 4'h0, 32'h0);
        @(negedge clk);
        chk("or_r1_rdata0", rd0, 32'h01010101);
        chk("or_plus1_valid1", 32'(rv1), 0);
        drive(0, 5'h02, 4'h0, 32'h0);
        @(negedge clk);
        chk("or_plus2_valid1", 32'(rv1), 1);
        chk("or_plus2_rdata1", rd1, 32'h01010101);
        chk("or_r2_rdata0", rd0, 32'h02020202);
        drive(0, 5'h03, 4'h0, 32'h0);
        @(negedge clk);
        chk("or_plus3_valid1", 32'(rv1), 1);
        chk("or_plus3_rdata1", rd1, 32'h02020202);
        chk("or_r3_rdata0", rd0, 32'h11223344);
        idle();
        @(negedge clk);
        chk("or_plus4_valid1", 32'(rv1), 1);
        chk("or_plus4_rdata1", rd1, 32'h11223344);
        chk("hold_valid0", 32'(rv0), 0);
        chk("hold_rdata0", rd0, 32'h11223344);
        @(negedge clk);
        chk("or_plus5_valid1", 32'(rv1), 0);
        chk("hold_rdata1", rd1, 32'h11223344);

        // Reset one cycle after a read accept: the read is dropped.
        drive(0, 5'h05, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        chk("pre_rst_valid0", 32'(rv0), 1);
        chk("pre_rst_rdata0", rd0, 32'hAA00CC00);
        resetn = 1'b0;
        #1;
        chk("async_valid0", 32'(rv0), 0);
        chk("async_rdata0", rd0, 0);
        chk("async_ready0", 32'(rdy0), 0);
        chk("async_busy0", 32'(busy0), 1);
        chk("async_rdata1", rd1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("dropped_valid1", 32'(rv1), 0);
        end
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("init_valid1", 32'(rv1), 0);
        end

        // Reset halfway through INIT: restart and full-length fill.
        resetn = 1'b0;
        #1;
        chk("mid_init_busy0", 32'(busy0), 1);
        chk("mid_init_ready0", 32'(rdy0), 0);
        chk("mid_init_valid0", 32'(rv0), 0);
        repeat (2) @(negedge clk);
        wait_init();

        drive(0, 5'h0F, 4'h0, 32'h0);
        @(negedge clk);
        chk("clr_0f_valid0", 32'(rv0), 1);
        chk("clr_0f_rdata0", rd0, 0);
        drive(0, 5'h1F, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        chk("clr_1f_rdata0", rd0, 0);
        chk("clr_0f_valid1", 32'(rv1), 1);
        chk("clr_0f_rdata1", rd1, 0);
        @(negedge clk);
        chk("clr_1f_valid1", 32'(rv1), 1);
        chk("clr_1f_rdata1", rd1, 0);

`ifdef SP_DATA_RAM_PARITY_EN
        drive(1, 5'h05, 4'hF, 32'h12345678);
        @(negedge clk);
        idle();
        dut0.g_lane[1].u_lane.mem[5][1] = ~dut0.g_lane[1].u_lane.mem[5][1];
        drive(0, 5'h05, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        chk("par_valid0", 32'(rv0), 1);
        chk("par_rdata0", rd0, 32'h12345478);
        chk("par_err0", 32'(pe0), 32'h2);
        @(negedge clk);
        chk("par_idle_err0", 32'(pe0), 0);
        chk("par_valid1", 32'(rv1), 1);
        chk("par_rdata1", rd1, 32'h12345678);
        chk("par_err1", 32'(pe1), 0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
